// File: rtl/msj_ramp_pkg.sv
// -----------------------------------------------------------------------------
// msj_ramp_pkg
// Shared types, limits and the saturating adder used by the setpoint ramp
// stage (msj_setpoint_ramp) and its helpers.
//   ramp_state_t : state encoding of the time-multiplexed step engine
//   SP_MAX/SP_MIN: signed 32-bit setpoint / target limits
//   sat_add32    : a + b computed on 33 bits, clamped to [SP_MIN, SP_MAX]
// -----------------------------------------------------------------------------
package msj_ramp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_APPLY = 2'd2
  } ramp_state_t;

  localparam logic signed [31:0] SP_MAX = 32'sh7fff_ffff;
  localparam logic signed [31:0] SP_MIN = 32'sh8000_0000;

  function automatic logic signed [31:0] sat_add32(input logic signed [31:0] a,
                                                   input logic signed [31:0] b);
    logic [32:0] sum;
    sum = {a[31], a} + {b[31], b};
    // The two top bits disagree only when the true sum left the 32-bit range.
    if (sum[32] != sum[31]) begin
      return sum[32] ? SP_MIN : SP_MAX;
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/msj_button_debounce.sv
// -----------------------------------------------------------------------------
// msj_button_debounce
// Debounces one active-low, asynchronous push button and emits a one-cycle
// pulse on each debounced press (falling edge of the raw level).
//   clock    : system clock
//   reset    : synchronous, active-high; button reads "released"
//   button_n : raw active-low button level
//   fall     : one-cycle pulse when a press has been stable for WINDOW_CYCLES
// -----------------------------------------------------------------------------
module msj_button_debounce #(
  parameter int WINDOW_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic button_n,
  output logic fall
);

  localparam int CNT_W = $clog2(WINDOW_CYCLES + 1);

  logic             sync_meta;
  logic             sync_q;
  logic             stable_q;
  logic [CNT_W-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_meta <= 1'b1;
      sync_q    <= 1'b1;
      stable_q  <= 1'b1;
      count_q   <= '0;
      fall      <= 1'b0;
    end else begin
      sync_meta <= button_n;
      sync_q    <= sync_meta;
      fall      <= 1'b0;
      if (sync_q == stable_q) begin
        // Any bounce back to the accepted level restarts the window.
        count_q <= '0;
      end else if (count_q == CNT_W'(WINDOW_CYCLES - 1)) begin
        stable_q <= sync_q;
        count_q  <= '0;
        fall     <= ~sync_q;
      end else begin
        count_q <= count_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/msj_setpoint_ramp.sv
// -----------------------------------------------------------------------------
// msj_setpoint_ramp
// Per-motor setpoint trajectory stage: holds a target per motor and walks the
// controller setpoint toward it by at most max_step counts per update pulse,
// using one shared IDLE -> CALC -> APPLY arithmetic path served round-robin.
//
// Build option: define MSJ_SP_BUTTONS_EN to build the button debouncers and
// button-driven target changes; otherwise the button ports are ignored.
//
// Ports:
//   clock, reset        : clock, synchronous active-high reset
//   target_write        : strobe loading target_value into target[target_motor]
//   target_motor        : motor index (>= NUMBER_OF_MOTORS is ignored)
//   target_value        : signed 32-bit target
//   max_step            : per-step limit, 0 = jump straight to target
//   update[i]           : request one ramp step for motor i
//   hold                : targets track the current setpoints
//   pull_buttons[i]     : active-low, +BUTTON_STEP on target i
//   release_buttons[i]  : active-low, -BUTTON_STEP on target i
//   release_all_button  : active-low, -BUTTON_STEP on every target
//   zero_pose_button    : active-low, every target to 0
//   sp                  : flattened setpoints, motor i at [32i+31:32i]
//   sp_valid[i]         : pulse the cycle after sp[i] is written
//   at_target[i]        : registered sp[i] == target[i]
// -----------------------------------------------------------------------------
module msj_setpoint_ramp
  import msj_ramp_pkg::*;
#(
  parameter int NUMBER_OF_MOTORS = 6,
  parameter int CLOCK_SPEED_HZ   = 50_000_000,
  parameter int BUTTON_STEP      = 10,
  parameter int DEBOUNCE_MS      = 20
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             target_write,
  input  logic [7:0]                       target_motor,
  input  logic signed [31:0]               target_value,
  input  logic [15:0]                      max_step,
  input  logic [NUMBER_OF_MOTORS-1:0]      update,
  input  logic                             hold,
  input  logic [NUMBER_OF_MOTORS-1:0]      pull_buttons,
  input  logic [NUMBER_OF_MOTORS-1:0]      release_buttons,
  input  logic                             release_all_button,
  input  logic                             zero_pose_button,
  output logic [32*NUMBER_OF_MOTORS-1:0]   sp,
  output logic [NUMBER_OF_MOTORS-1:0]      sp_valid,
  output logic [NUMBER_OF_MOTORS-1:0]      at_target
);

  localparam int N     = NUMBER_OF_MOTORS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic signed [31:0] BUTTON_DELTA = 32'(BUTTON_STEP);

  // ---------------------------------------------------------------------------
  // Button edges
  // ---------------------------------------------------------------------------
  logic [N-1:0] pull_edge;
  logic [N-1:0] release_edge;
  logic         zero_edge;
  logic         release_all_edge;

`ifdef MSJ_SP_BUTTONS_EN
  localparam int WINDOW_RAW = CLOCK_SPEED_HZ / 1000 * DEBOUNCE_MS;
  localparam int WINDOW     = (WINDOW_RAW < 1) ? 1 : WINDOW_RAW;

  for (genvar i = 0; i < N; i++) begin : g_motor_buttons
    msj_button_debounce #(.WINDOW_CYCLES(WINDOW)) u_pull (
      .clock   (clock),
      .reset   (reset),
      .button_n(pull_buttons[i]),
      .fall    (pull_edge[i])
    );
    msj_button_debounce #(.WINDOW_CYCLES(WINDOW)) u_release (
      .clock   (clock),
      .reset   (reset),
      .button_n(release_buttons[i]),
      .fall    (release_edge[i])
    );
  end

  msj_button_debounce #(.WINDOW_CYCLES(WINDOW)) u_zero_pose (
    .clock   (clock),
    .reset   (reset),
    .button_n(zero_pose_button),
    .fall    (zero_edge)
  );
  msj_button_debounce #(.WINDOW_CYCLES(WINDOW)) u_release_all (
    .clock   (clock),
    .reset   (reset),
    .button_n(release_all_button),
    .fall    (release_all_edge)
  );
`else
  assign pull_edge        = '0;
  assign release_edge     = '0;
  assign zero_edge        = 1'b0;
  assign release_all_edge = 1'b0;

  logic unused_buttons;
  assign unused_buttons = ^{pull_buttons, release_buttons, release_all_button,
                            zero_pose_button, 32'(CLOCK_SPEED_HZ), 32'(DEBOUNCE_MS)};
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  ramp_state_t        state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   cur_idx;
  logic [N-1:0]       pending;
  logic [N-1:0]       applied;
  logic signed [32:0] diff;
  logic signed [31:0] sp_q     [N];
  logic signed [31:0] target_q [N];

  // ---------------------------------------------------------------------------
  // Round-robin scan and step arithmetic
  // ---------------------------------------------------------------------------
  logic               scan_found;
  logic [IDX_W-1:0]   scan_idx;
  int                 scan_cand;
  logic [N-1:0]       apply_clear;
  logic signed [31:0] sp_cur;
  logic signed [31:0] next_sp;
  logic [32:0]        abs_diff;

  // NOTE: every variable driven here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    scan_found = 1'b0;
    scan_idx   = '0;
    scan_cand  = 0;
    for (int o = 0; o < N; o++) begin
      scan_cand = int'(ptr) + o;
      if (scan_cand >= N) scan_cand = scan_cand - N;
      if (!scan_found && pending[IDX_W'(scan_cand)]) begin
        scan_found = 1'b1;
        scan_idx   = IDX_W'(scan_cand);
      end
    end

    apply_clear = '0;
    if (state == ST_APPLY) apply_clear[cur_idx] = 1'b1;

    sp_cur   = sp_q[cur_idx];
    abs_diff = diff[32] ? 33'(-diff) : 33'(diff);
    // The registered diff is applied, so a target change during the step
    // only matters at the next service of this motor.
    if (max_step == 16'd0 || abs_diff <= {17'd0, max_step}) begin
      next_sp = sp_cur + diff[31:0];
    end else if (diff[32]) begin
      next_sp = sp_cur - 32'(max_step);
    end else begin
      next_sp = sp_cur + 32'(max_step);
    end
  end

  // ---------------------------------------------------------------------------
  // Step engine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      cur_idx <= '0;
      diff    <= '0;
      pending <= '0;
      applied <= '0;
    end else begin
      // A new request in the clearing cycle survives.
      pending <= (pending & ~apply_clear) | update;
      applied <= '0;
      case (state)
        ST_IDLE: begin
          if (scan_found) begin
            cur_idx <= scan_idx;
            state   <= ST_CALC;
          end
        end
        ST_CALC: begin
          diff  <= {target_q[cur_idx][31], target_q[cur_idx]}
                 - {sp_q[cur_idx][31], sp_q[cur_idx]};
          state <= ST_APPLY;
        end
        ST_APPLY: begin
          applied[cur_idx] <= 1'b1;
          ptr   <= (cur_idx == IDX_W'(N - 1)) ? '0 : cur_idx + 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Setpoints and targets
  // ---------------------------------------------------------------------------
  // NOTE: these per-motor arrays are reset explicitly; the PD controllers read
  // sp straight out of reset, so it must be a known 0, not RAM garbage.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N; i++) sp_q[i] <= '0;
    end else if (state == ST_APPLY) begin
      sp_q[cur_idx] <= next_sp;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N; i++) target_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (hold) begin
          target_q[i] <= sp_q[i];
        end else if (zero_edge) begin
          target_q[i] <= '0;
        end else if (target_write && target_motor == 8'(i)) begin
          target_q[i] <= target_value;
        end else if (release_all_edge) begin
          target_q[i] <= sat_add32(target_q[i], -BUTTON_DELTA);
        end else if (pull_edge[i] && !release_edge[i]) begin
          target_q[i] <= sat_add32(target_q[i], BUTTON_DELTA);
        end else if (release_edge[i] && !pull_edge[i]) begin
          target_q[i] <= sat_add32(target_q[i], -BUTTON_DELTA);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      sp_valid  <= '0;
      at_target <= '1;
    end else begin
      sp_valid <= applied;
      for (int i = 0; i < N; i++) at_target[i] <= (sp_q[i] == target_q[i]);
    end
  end

  always_comb begin
    sp = '0;
    for (int i = 0; i < N; i++) sp[32*i +: 32] = sp_q[i];
  end

endmodule
